avg_pool2x2_layer: RTL and testbench

Streaming 2x2 average-pool downsampler, stride 2, the inverse-direction counterpart of the zero-stuffing upsampler inside `trans_conv2d_4x4_layer`. It accepts one raster-order pixel per handshake on the same `valid_in`/`data_in`/`ready_out` interface the layers use and emits one pooled pixel per 2x2 block on `valid_out`/`data_out`. It sits in the discriminator path, between conv layers, to halve each spatial dimension. Fixed-point scale is unchanged, so no format conversion is needed downstream.

---
 rtl/avg_pool2x2_layer.sv | 148 ++++++++++++++
 tb/tb_avg_pool2x2_layer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool2x2_layer.sv
// Streaming 2x2 average-pool downsampler, stride 2.
// Raster pixels in, one floored block mean out per 2x2 block.
module avg_pool2x2_layer #(
  parameter int IN_WIDTH   = 16,
  parameter int IN_HEIGHT  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         ready_out,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  localparam int HW = IN_WIDTH / 2;
  localparam int CW = $clog2(IN_WIDTH);
  localparam int RW = $clog2(IN_HEIGHT);
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;
  localparam int LW = DATA_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ROW_EVEN,
    ROW_ODD,
    FRAME_END
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;

  logic ready_q, ready_d;
  logic valid_q, valid_d;

  logic signed [LW-1:0] linebuf_q [HW];

  logic                 lb_we;
  logic [IW-1:0]        lb_idx;
  logic signed [LW-1:0] lb_wdata;
  logic signed [LW-1:0] lb_rdata;
  logic signed [SW-1:0] sum;

  logic accept;
  logic col_last;
  logic row_last;
  logic col_odd;

  assign accept   = valid_in && ready_q;
  assign col_last = (col_q == CW'(IN_WIDTH - 1));
  assign row_last = (row_q == RW'(IN_HEIGHT - 1));
  assign col_odd  = col_q[0];
  assign lb_idx   = IW'(col_q >> 1);
  assign lb_rdata = linebuf_q[lb_idx];

  // Pair sums keep one guard bit, block sums two, so nothing wraps.
  assign lb_wdata = {hold_q[DATA_WIDTH-1], hold_q}
                  + {data_in[DATA_WIDTH-1], data_in};

  assign sum = {{2{hold_q[DATA_WIDTH-1]}}, hold_q}
             + {{2{data_in[DATA_WIDTH-1]}}, data_in}
             + {lb_rdata[LW-1], lb_rdata};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lb_we   = 1'b0;

    unique case (state_q)
      ROW_EVEN, ROW_ODD: begin
        if (accept) begin
          col_d = col_last ? '0 : col_q + 1'b1;

          unique case (1'b1)
            !col_odd: hold_d = data_in;
            col_odd && (state_q == ROW_EVEN): lb_we = 1'b1;
            col_odd && (state_q == ROW_ODD): begin
              valid_d = 1'b1;
              data_d  = DATA_WIDTH'(sum >>> 2);
            end
            default: ;
          endcase

          if (col_last) begin
            if (state_q == ROW_EVEN) begin
              state_d = ROW_ODD;
              row_d   = row_q + 1'b1;
            end else if (row_last) begin
              state_d = FRAME_END;
            end else begin
              state_d = ROW_EVEN;
              row_d   = row_q + 1'b1;
            end
          end
        end
      end
      FRAME_END: begin
        state_d = ROW_EVEN;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = ROW_EVEN;
    endcase

    ready_d = (state_d != FRAME_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ROW_EVEN;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Rewritten on every even row before being read, so no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= lb_wdata;
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_avg_pool2x2_layer.sv
// Bench for avg_pool2x2_layer: directed and random 4x4 frames
// checked cycle by cycle against a block-mean reference model.
module tb_avg_pool2x2_layer;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = 16;
  localparam int NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic                 ready_out;
  logic                 valid_out;
  logic signed [DW-1:0] data_out;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;

  bit                   exp_valid = 1'b0;
  bit                   exp_ready = 1'b0;
  logic signed [DW-1:0] last_data = '0;

  int px [NPIX];

  always #5 clk = ~clk;

  avg_pool2x2_layer #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  function automatic int floor4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int block_avg(input int br, input int bc);
    int r0;
    int c0;
    int s;
    r0 = 2 * br;
    c0 = 2 * bc;
    s  = px[r0*W + c0] + px[r0*W + c0 + 1]
       + px[(r0+1)*W + c0] + px[(r0+1)*W + c0 + 1];
    return floor4(s);
  endfunction

  task automatic check(input string tag);
    n_checks++;
    assert (valid_out === exp_valid) else begin
      n_err++;
      $error("FAIL %s valid_out got %b want %b", tag, valid_out, exp_valid);
    end
    if (valid_out === 1'b1) pulses++;
    n_checks++;
    assert (data_out === last_data) else begin
      n_err++;
      $error("FAIL %s data_out got %0d want %0d", tag, data_out, last_data);
    end
    n_checks++;
    assert (ready_out === exp_ready) else begin
      n_err++;
      $error("FAIL %s ready_out got %b want %b", tag, ready_out, exp_ready);
    end
  endtask

  // Called at a falling edge; presents px[p] until it is accepted.
  task automatic run_frame(input int n, input bit gaps, input string tag);
    int p;
    int guard;
    bit v;
    bit acc;
    p = 0;
    guard = 0;
    while (p < n && guard < 400) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      valid_in = v;
      data_in  = DW'(px[p]);
      acc = v && (ready_out === 1'b1);
      exp_valid = 1'b0;
      exp_ready = 1'b1;
      if (acc) begin
        if (((p / W) % 2 == 1) && ((p % W) % 2 == 1)) begin
          exp_valid = 1'b1;
          last_data = DW'(block_avg((p / W) / 2, (p % W) / 2));
        end
        if (p == NPIX - 1) exp_ready = 1'b0;
        p++;
      end
      @(posedge clk);
      @(negedge clk);
      check(tag);
      guard++;
    end
    valid_in = 1'b0;
    n_checks++;
    assert (p == n) else begin
      n_err++;
      $error("FAIL %s accepted got %0d want %0d", tag, p, n);
    end
  endtask

  task automatic idle(input int k, input string tag);
    valid_in = 1'b0;
    repeat (k) begin
      exp_valid = 1'b0;
      exp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check(tag);
    end
  endtask

  task automatic check_pulses(input int want, input string tag);
    n_checks++;
    assert (pulses == want) else begin
      n_err++;
      $error("FAIL %s pulses got %0d want %0d", tag, pulses, want);
    end
    pulses = 0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++) px[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) px[i] = i + 1;
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;

    repeat (2) @(negedge clk);
    exp_ready = 1'b0;
    check("reset");

    rst_n = 1'b1;
    exp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release");
    pulses = 0;

    fill_const(8);
    run_frame(NPIX, 1'b0, "const8");
    idle(1, "const8_end");
    check_pulses(4, "const8");

    fill_ramp();
    run_frame(NPIX, 1'b0, "ramp");
    idle(1, "ramp_end");
    check_pulses(4, "ramp");

    fill_const(0);
    px[0] = -1;
    px[1] = -2;
    px[W] = -1;
    px[W+1] = -2;
    run_frame(NPIX, 1'b0, "negfloor");
    idle(1, "negfloor_end");
    check_pulses(4, "negfloor");

    fill_ramp();
    run_frame(NPIX, 1'b1, "gaps_a");
    run_frame(NPIX, 1'b1, "gaps_b");
    idle(1, "gaps_end");
    check_pulses(8, "gaps");

    fill_const(32767);
    run_frame(NPIX, 1'b0, "max");
    fill_const(-32768);
    run_frame(NPIX, 1'b0, "min");
    idle(1, "extreme_end");
    check_pulses(8, "extreme");

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        px[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_frame(NPIX, f[0], "random");
    end
    idle(2, "random_end");
    check_pulses(80, "random");

    fill_ramp();
    run_frame(6, 1'b1, "partial");
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_ready = 1'b0;
    last_data = '0;
    check("async_rst");
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release");

    fill_const(8);
    run_frame(NPIX, 1'b0, "after_rst");
    idle(2, "after_rst_end");
    check_pulses(4, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
